// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters with a 3-state FSM.
// Define ALU_ARB_RR_EN for round-robin arbitration; the default is fixed priority to requester 0.
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_req_valid,
    output logic [1:0]        o_req_ready,
    input  logic [DATA_W-1:0] i_req0_a,
    input  logic [DATA_W-1:0] i_req0_b,
    input  logic [DATA_W-1:0] i_req1_a,
    input  logic [DATA_W-1:0] i_req1_b,
    input  logic [2:0]        i_req0_alucrtl,
    input  logic [2:0]        i_req1_alucrtl,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [2:0]        o_alu_alucrtl,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic              i_alu_zero,
    output logic [1:0]        o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_result,
    output logic              o_rsp_zero,
    input  logic [1:0]        i_rsp_ready,
    output logic              o_busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, b_q, res_q;
    logic [2:0]        ctl_q;
    logic              owner_q, zero_q, gnt, req_hs, rsp_hs;
`ifdef ALU_ARB_RR_EN
    logic last_q;
    assign gnt = (&i_req_valid) ? ~last_q : ~i_req_valid[0];
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) last_q <= 1'b1;
        else if (req_hs) last_q <= gnt;
    end
`else
    assign gnt = ~i_req_valid[0];
`endif
    // Ready is masked during reset because the state register alone is already IDLE then.
    assign o_req_ready = (state_q == IDLE && !i_rst) ? (i_req_valid & (gnt ? 2'b10 : 2'b01)) : 2'b00;
    assign req_hs = |o_req_ready;
    assign rsp_hs = state_q == RESP && i_rsp_ready[owner_q];
    always_comb begin
        state_d = state_q;
        state_d = (state_q == IDLE) ? (req_hs ? EXEC : IDLE) :
                  (state_q == EXEC) ? RESP : (rsp_hs ? IDLE : RESP);
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ctl_q   <= '0;
            owner_q <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req_hs) begin
                a_q     <= gnt ? i_req1_a : i_req0_a;
                b_q     <= gnt ? i_req1_b : i_req0_b;
                ctl_q   <= gnt ? i_req1_alucrtl : i_req0_alucrtl;
                owner_q <= gnt;
            end
            if (state_q == EXEC) begin
                res_q  <= i_alu_result;
                zero_q <= i_alu_zero;
            end
        end
    end
    assign o_alu_a       = a_q;
    assign o_alu_b       = b_q;
    assign o_alu_alucrtl = ctl_q;
    assign o_rsp_valid   = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign o_rsp_result  = res_q;
    assign o_rsp_zero    = zero_q;
    assign o_busy        = state_q != IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench with a transaction-level model checked every cycle.
module tb_alu_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic [1:0]  vld = 2'b00, rdy, rsp_v, rsp_rdy = 2'b11;
    logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0, alu_a, alu_b, alu_r, rsp_r;
    logic [2:0]  c0 = 0, c1 = 0, alu_c;
    logic        alu_z, rsp_z, busy;
    int          errs = 0, checks = 0;
    int          m_phase = 0, m_owner = 0, m_last = 1;
    logic [31:0] m_a = 0, m_b = 0, m_res = 0;
    logic [2:0]  m_c = 0;
    logic        m_zero = 0;
    int          glog[$];
`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    alu_arbiter #(.DATA_W(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(vld), .o_req_ready(rdy),
        .i_req0_a(a0), .i_req0_b(b0), .i_req1_a(a1), .i_req1_b(b1),
        .i_req0_alucrtl(c0), .i_req1_alucrtl(c1),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_alucrtl(alu_c),
        .i_alu_result(alu_r), .i_alu_zero(alu_z),
        .o_rsp_valid(rsp_v), .o_rsp_result(rsp_r), .o_rsp_zero(rsp_z),
        .i_rsp_ready(rsp_rdy), .o_busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        case (c)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return {31'b0, $signed(a) < $signed(b)};
            default: return 32'hA5A5_0F0F;
        endcase
    endfunction

    function automatic int pick(input logic [1:0] v, input int last);
        if (v == 2'b11) return RR ? 1 - last : 0;
        return v[0] ? 0 : 1;
    endfunction

    assign alu_r = alu_fn(alu_a, alu_b, alu_c);
    assign alu_z = alu_r == 32'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: one operation in flight, owner chosen by the arbitration rule, result from the ALU rule.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_last  <= 1;
        end else if (m_phase == 0) begin
            if (vld != 2'b00) begin
                m_owner <= pick(vld, m_last);
                m_last  <= pick(vld, m_last);
                m_a     <= pick(vld, m_last) == 1 ? a1 : a0;
                m_b     <= pick(vld, m_last) == 1 ? b1 : b0;
                m_c     <= pick(vld, m_last) == 1 ? c1 : c0;
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            m_res   <= alu_fn(m_a, m_b, m_c);
            m_zero  <= alu_fn(m_a, m_b, m_c) == 32'd0;
            m_phase <= 2;
        end else if (rsp_rdy[m_owner]) begin
            m_phase <= 0;
        end
    end

    always @(posedge clk)
        if (!rst && (vld & rdy) != 2'b00) glog.push_back(rdy[1] ? 1 : 0);

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready", rdy, 0);
            chk("rst_rsp_valid", rsp_v, 0);
            chk("rst_result", rsp_r, 0);
            chk("rst_zero", rsp_z, 0);
            chk("rst_busy", busy, 0);
            chk("rst_alu_a", alu_a, 0);
            chk("rst_alu_b", alu_b, 0);
            chk("rst_alu_ctl", alu_c, 0);
        end else begin
            chk("ready", rdy, (m_phase == 0 && vld != 2'b00) ? (pick(vld, m_last) == 1 ? 2 : 1) : 0);
            chk("busy", busy, m_phase != 0);
            chk("rsp_valid", rsp_v, m_phase == 2 ? (m_owner == 1 ? 2 : 1) : 0);
            if (m_phase == 2) begin
                chk("rsp_result", rsp_r, m_res);
                chk("rsp_zero", rsp_z, m_zero);
            end
            if (m_phase != 0) begin
                chk("alu_a", alu_a, m_a);
                chk("alu_b", alu_b, m_b);
                chk("alu_ctl", alu_c, m_c);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input int n, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                         input logic [31:0] er, input logic ez, input string nm);
        int t;
        if (n == 0) begin a0 = a; b0 = b; c0 = c; end
        else begin a1 = a; b1 = b; c1 = c; end
        vld = (n == 0) ? 2'b01 : 2'b10;
        t = 0;
        @(negedge clk);
        while (!rdy[n] && t < 10) begin @(negedge clk); t++; end
        chk({nm, "_accept"}, rdy[n], 1);
        step();
        vld = 2'b00;
        t = 0;
        @(negedge clk);
        while (rsp_v == 2'b00 && t < 10) begin @(negedge clk); t++; end
        chk({nm, "_valid"}, rsp_v, n == 0 ? 1 : 2);
        chk({nm, "_result"}, rsp_r, er);
        chk({nm, "_zero"}, rsp_z, ez);
        step();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("lit_reset_busy", busy, 0);
        chk("lit_reset_rsp_valid", rsp_v, 0);
        step();
        rst = 1'b0;
        // single SUB 5-3, latency pinned by hand
        a0 = 5; b0 = 3; c0 = 3'b001; vld = 2'b01;
        @(negedge clk);
        chk("lit_ready_01", rdy, 2'b01);
        step();
        vld = 2'b00;
        @(negedge clk);
        chk("lit_alu_a", alu_a, 5);
        chk("lit_alu_b", alu_b, 3);
        chk("lit_alu_ctl", alu_c, 1);
        chk("lit_exec_no_rsp", rsp_v, 0);
        chk("lit_exec_busy", busy, 1);
        step();
        @(negedge clk);
        chk("lit_rsp_valid", rsp_v, 2'b01);
        chk("lit_rsp_result", rsp_r, 2);
        chk("lit_rsp_zero", rsp_z, 0);
        step();
        @(negedge clk);
        chk("lit_idle_after_hs", busy, 0);
        step();
        do_op(1, 32'd7, 32'd7, 3'b001, 32'd0, 1'b1, "sub_eq");
        do_op(0, 32'hFFFF_FFFF, 32'd1, 3'b101, 32'd1, 1'b0, "slt");
        do_op(1, 32'hF0, 32'h3C, 3'b100, 32'hCC, 1'b0, "xor");
        do_op(0, 32'hF0, 32'h3C, 3'b010, 32'h30, 1'b0, "and");
        do_op(1, 32'hF0, 32'h3C, 3'b011, 32'hFC, 1'b0, "or");
        do_op(0, 32'hFFFF_FFFF, 32'd1, 3'b000, 32'd0, 1'b1, "add_wrap");
        // response backpressure
        rsp_rdy = 2'b00;
        a0 = 9; b0 = 4; c0 = 3'b000; vld = 2'b01;
        step();
        vld = 2'b00;
        step();
        vld = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", rsp_v, 2'b01);
            chk("bp_result", rsp_r, 13);
            chk("bp_busy", busy, 1);
            chk("bp_ready", rdy, 2'b00);
            step();
        end
        rsp_rdy = 2'b10;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_nonowner_ignored", rsp_v, 2'b01);
            step();
        end
        vld = 2'b00;
        rsp_rdy = 2'b01;
        step();
        @(negedge clk);
        chk("bp_released", busy, 0);
        rsp_rdy = 2'b11;
        step();
        // asynchronous reset while in EXEC, with an unusual control code
        a0 = 1; b0 = 2; c0 = 3'b110; vld = 2'b01;
        step();
        vld = 2'b00;
        @(negedge clk);
        chk("ctl_110_passthru", alu_c, 3'b110);
        #2;
        rst = 1'b1;
        vld = 2'b01;
        #1;
        chk("async_busy", busy, 0);
        chk("async_alu_a", alu_a, 0);
        chk("async_alu_ctl", alu_c, 0);
        chk("async_ready", rdy, 0);
        chk("async_rsp_valid", rsp_v, 0);
        step();
        rst = 1'b0;
        vld = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_rsp_after_reset", rsp_v, 0);
            step();
        end
        do_op(0, 32'd100, 32'd1, 3'b001, 32'd99, 1'b0, "post_reset");
        // contention from a fresh reset
        reset_pulse();
        glog.delete();
        a0 = 10; b0 = 1; c0 = 3'b000;
        a1 = 20; b1 = 2; c1 = 3'b001;
        vld = 2'b11;
        t = 0;
        while (glog.size() < 4 && t < 60) begin step(); t++; end
        vld = 2'b00;
        chk("contention_grant_count", glog.size() >= 4, 1);
        for (int k = 0; k < 4 && k < glog.size(); k++)
            chk($sformatf("contention_grant%0d", k), glog[k], RR ? k % 2 : 0);
        repeat (5) step();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
